mod12_cmd_arbiter: RTL and testbench
====================================

# mod12_cmd_arbiter

Command controller and two-port arbiter for the mod-12 up/down counter. Two requesters issue "load start value, count N steps in a direction" commands. The block grants them round-robin and sequences the counter's `load`/`mode`/`datain` pins. It then captures `dataout` after N steps, checks it against an internally computed expected value, and returns a tagged response. It sits between the test/control agents and the counter DUT, driving the counter's input pins in place of the driver.

## Interface
Parameters:
- `MOD`, 12, counter modulus; legal start values are 0..MOD-1.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  command valid, per requester.
- `req0_ready`, `req1_ready`  out  1  command accepted this cycle.
- `req0_start`, `req1_start`  in  4  load value.
- `req0_dir`, `req1_dir`  in  1  1 = up, 0 = down.
- `req0_len`, `req1_len`  in  4  count steps, 0..15.
- `cnt_load`  out  1  to counter `load`.
- `cnt_mode`  out  1  to counter `mode`.
- `cnt_datain`  out  4  to counter `datain`.
- `cnt_dataout`  in  4  from counter `dataout` (registered counter output).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accepted.
- `rsp_id`  out  1  requester index.
- `rsp_data`  out  4  captured counter value.
- `rsp_err`  out  1  illegal start value or result mismatch.

## Operation
- FSM states: IDLE, LOAD, RUN, CAPTURE, RESP.
- **IDLE**
  - If any `reqX_valid`, grant one requester; if both, grant the one not granted last.
  - Assert that requester's `reqX_ready` combinationally for that cycle only.
  - On the handshake, latch start/dir/len/id.
  - If start < MOD, go to LOAD; otherwise go to RESP with `rsp_err=1`, `rsp_data=0`, and no `cnt_load` pulse.
- **LOAD** (1 cycle): `cnt_load=1`, `cnt_datain=start`, `cnt_mode=dir`.
- **RUN** (len cycles, skipped if len=0): `cnt_load=0`, `cnt_mode=dir`. The counter steps once per cycle.
- **CAPTURE** (1 cycle): register `cnt_dataout` into `rsp_data`.
  - Expected value: up = (start+len) mod MOD; down = (start−len) mod MOD.
  - Compute it with 5-bit arithmetic, one conditional subtract/add of MOD per wrap; len ≤ 15 needs up to 2 corrections.
  - `rsp_err` = (captured ≠ expected).
- **RESP**
  - Hold `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err` stable until `rsp_ready`.
  - On the handshake, return to IDLE and update the round-robin pointer.
- Counter wrap semantics: up goes 11→0; down goes 0→11.
- Outside LOAD, `cnt_datain` = 0 and `cnt_load` = 0.
- `cnt_mode` retains its last value in IDLE and RESP.
- No `reqX_ready` is asserted outside IDLE, so one command is in flight at a time.
- Requester inputs are sampled only on the handshake.

## Timing
- Reset (`rst`=0 at a posedge):
  - State goes to IDLE; any in-flight command is discarded with no response.
  - All outputs read 0, including `cnt_mode` and `rsp_*`.
  - The round-robin pointer favours req0 first.
- Latency for a command accepted in cycle T:
  - LOAD at T+1.
  - RUN at T+2..T+1+len.
  - CAPTURE at T+2+len.
  - `rsp_valid` first high at T+3+len.
- Illegal start value: `rsp_valid` is high at T+1.
- Back-to-back: the next `reqX_ready` can be asserted no earlier than the cycle after the `rsp` handshake.
- A request arriving during LOAD/RUN/CAPTURE/RESP waits; its valid must stay high.

## Test plan
- **Reset**: `rst`=0 for 2 cycles mid-RUN → next cycle all outputs 0, state IDLE, no `rsp_valid` afterwards.
- **Up with wrap**: req0 start=10, dir=1, len=3 at T.
  - `cnt_load`=1 with `datain`=10 at T+1.
  - At T+6: `rsp_valid`=1, `rsp_data`=1, `rsp_id`=0, `rsp_err`=0.
- **Down with wrap**: req1 start=1, dir=0, len=4 → `rsp_data`=9, `rsp_id`=1, `rsp_err`=0.
- **Zero length**: len=0, start=7, dir=1 → `rsp_data`=7 at T+3.
- **Fairness**: both valid continuously, `rsp_ready`=1 → grants alternate 0,1,0,1 for 4 commands.
- **Illegal start and response backpressure**:
  - start=13 → `rsp_err`=1, `rsp_data`=0 at T+1, no `cnt_load` pulse.
  - Bench forces `cnt_dataout` wrong during CAPTURE → `rsp_err`=1.
  - `rsp_ready` held low 5 cycles → `rsp_*` stable and both `ready` outputs stay 0.

Source files
------------

// File: rtl/mod12_cmd_arbiter.sv
// Round-robin command arbiter and sequencer for a mod-MOD up/down counter:
// loads a start value, steps it len times, captures the result and checks it.
module mod12_cmd_arbiter #(
  parameter int unsigned MOD = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_start,
  input  logic [3:0] req1_start,
  input  logic       req0_dir,
  input  logic       req1_dir,
  input  logic [3:0] req0_len,
  input  logic [3:0] req1_len,
  output logic       cnt_load,
  output logic       cnt_mode,
  output logic [3:0] cnt_datain,
  input  logic [3:0] cnt_dataout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  output logic       rsp_err
);

  localparam logic [4:0] MOD5 = 5'(MOD);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE,
    RESP
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_prio1;
  logic [3:0] r_start;
  logic [3:0] r_len;
  logic [3:0] r_run;
  logic       r_dir;
  logic       r_id;
  logic       r_mode;
  logic [3:0] r_rsp_data;
  logic       r_rsp_err;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_hs;
  logic [3:0] w_start;
  logic [3:0] w_len;
  logic       w_dir;
  logic       w_legal;
  logic [4:0] w_up0, w_up1, w_up2;
  logic [4:0] w_dn0, w_dn1, w_dn2;
  logic [4:0] w_expect;

  assign w_hs    = w_gnt0 | w_gnt1;
  assign w_start = w_gnt1 ? req1_start : req0_start;
  assign w_len   = w_gnt1 ? req1_len   : req0_len;
  assign w_dir   = w_gnt1 ? req1_dir   : req0_dir;
  assign w_legal = ({1'b0, w_start} < MOD5);

  // Up to two wrap corrections cover len <= 15; a set bit 4 marks a negative down result.
  assign w_up0    = {1'b0, r_start} + {1'b0, r_len};
  assign w_up1    = (w_up0 >= MOD5) ? (w_up0 - MOD5) : w_up0;
  assign w_up2    = (w_up1 >= MOD5) ? (w_up1 - MOD5) : w_up1;
  assign w_dn0    = {1'b0, r_start} - {1'b0, r_len};
  assign w_dn1    = w_dn0[4] ? (w_dn0 + MOD5) : w_dn0;
  assign w_dn2    = w_dn1[4] ? (w_dn1 + MOD5) : w_dn1;
  assign w_expect = r_dir ? w_up2 : w_dn2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_gnt0     = 1'b0;
    w_gnt1     = 1'b0;
    cnt_load   = 1'b0;
    cnt_datain = '0;
    rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0_valid && (!req1_valid || !r_prio1)) begin
          w_gnt0 = 1'b1;
        end else if (req1_valid) begin
          w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) begin
          w_next = w_legal ? LOAD : RESP;
        end
      end
      LOAD: begin
        cnt_load   = 1'b1;
        cnt_datain = r_start;
        w_next     = (r_len == 4'd0) ? CAPTURE : RUN;
      end
      RUN: begin
        if (r_run == 4'd1) begin
          w_next = CAPTURE;
        end
      end
      CAPTURE: begin
        w_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio1    <= 1'b0;
      r_start    <= '0;
      r_len      <= '0;
      r_run      <= '0;
      r_dir      <= 1'b0;
      r_id       <= 1'b0;
      r_mode     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_hs) begin
        r_start <= w_start;
        r_len   <= w_len;
        r_run   <= w_len;
        r_dir   <= w_dir;
        r_id    <= w_gnt1;
        if (w_legal) begin
          r_mode <= w_dir;
        end else begin
          r_rsp_data <= '0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == RUN) begin
        r_run <= r_run - 4'd1;
      end
      if (r_state == CAPTURE) begin
        r_rsp_data <= cnt_dataout;
        r_rsp_err  <= ({1'b0, cnt_dataout} != w_expect);
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_prio1 <= ~r_id;
      end
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign cnt_mode   = r_mode;
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_mod12_cmd_arbiter.sv
// Scoreboard bench for mod12_cmd_arbiter with a behavioural mod-12 counter attached.
module tb_mod12_cmd_arbiter;

  typedef struct {
    logic [3:0] start;
    logic       dir;
    logic [3:0] len;
  } cmd_t;

  typedef struct {
    int id;
    int data;
    int err;
    int due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_start = '0, req1_start = '0;
  logic       req0_dir = 1'b0, req1_dir = 1'b0;
  logic [3:0] req0_len = '0, req1_len = '0;
  logic       cnt_load, cnt_mode;
  logic [3:0] cnt_datain, cnt_dataout;
  logic       rsp_valid, rsp_id, rsp_err;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_data;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pref = 0;
  int   mode_m = 0;
  int   exp_load_cyc = -1;
  int   exp_datain = 0;
  bit   corrupt = 1'b0;
  bit   rand_ready = 1'b0;
  bit   prev_valid = 1'b0;
  bit   pv[2];
  cmd_t pc[2];
  exp_t sbq[$];
  logic [3:0] cnt_q = '0;

  mod12_cmd_arbiter #(.MOD(12)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_start(req0_start), .req1_start(req1_start),
    .req0_dir(req0_dir), .req1_dir(req1_dir),
    .req0_len(req0_len), .req1_len(req1_len),
    .cnt_load(cnt_load), .cnt_mode(cnt_mode),
    .cnt_datain(cnt_datain), .cnt_dataout(cnt_dataout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mod-12 counter seen by the arbiter; corrupt flips bit 0 of what it reads back.
  always @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_datain;
    else if (cnt_mode) cnt_q <= (cnt_q == 4'd11) ? 4'd0 : cnt_q + 4'd1;
    else cnt_q <= (cnt_q == 4'd0) ? 4'd11 : cnt_q - 4'd1;
  end
  assign cnt_dataout = cnt_q ^ {3'b000, corrupt};

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      rsp_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_result(input int s, input int d, input int l);
    if (d != 0) return (s + l) % 12;
    return ((s - l) % 12 + 12) % 12;
  endfunction

  // Monitor: compares everything the DUT presents against the bench's expectations.
  always @(negedge clk) begin
    if (rst) begin
      chk("cnt_load", cnt_load, (cyc == exp_load_cyc) ? 1 : 0);
      chk("cnt_datain", cnt_datain, (cyc == exp_load_cyc) ? exp_datain : 0);
      chk("cnt_mode", cnt_mode, mode_m);
      if (sbq.size() > 0) begin
        chk("req0_ready_busy", req0_ready, 0);
        chk("req1_ready_busy", req1_ready, 0);
      end
      if (rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("rsp_valid_spurious", rsp_valid, 0);
        end else begin
          if (!prev_valid) chk("rsp_latency", cyc, sbq[0].due);
          chk("rsp_id", rsp_id, sbq[0].id);
          chk("rsp_data", rsp_data, sbq[0].data);
          chk("rsp_err", rsp_err, sbq[0].err);
          if (rsp_ready) begin
            pref = (sbq[0].id == 0) ? 1 : 0;
            void'(sbq.pop_front());
          end
        end
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic apply();
    req0_valid = pv[0];
    req0_start = pc[0].start;
    req0_dir   = pc[0].dir;
    req0_len   = pc[0].len;
    req1_valid = pv[1];
    req1_start = pc[1].start;
    req1_dir   = pc[1].dir;
    req1_len   = pc[1].len;
  endtask

  task automatic offer(input int p, input int s, input int d, input int l);
    pv[p]       = 1'b1;
    pc[p].start = 4'(s);
    pc[p].dir   = (d != 0);
    pc[p].len   = 4'(l);
    apply();
  endtask

  task automatic serve(output int g);
    bit   got;
    int   pred;
    int   s;
    int   l;
    int   d;
    exp_t e;
    got = 1'b0;
    g   = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout: no reqX_ready within 300 cycles, required a grant");
      return;
    end
    pred = (pv[0] && pv[1]) ? pref : (pv[1] ? 1 : 0);
    g = req1_ready ? 1 : 0;
    chk("grant_onehot", int'(req0_ready) + int'(req1_ready), 1);
    chk("grant", g, pred);
    @(posedge clk);
    #1;
    s = int'(pc[g].start);
    l = int'(pc[g].len);
    d = int'(pc[g].dir);
    e.id = g;
    if (s < 12) begin
      e.data = ref_result(s, d, l) ^ int'(corrupt);
      e.err  = int'(corrupt);
      e.due  = cyc + 2 + l;
      exp_load_cyc = cyc;
      exp_datain   = s;
      mode_m       = d;
    end else begin
      e.data = 0;
      e.err  = 1;
      e.due  = cyc;
      exp_load_cyc = -1;
    end
    sbq.push_back(e);
    pv[g] = 1'b0;
    apply();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
  endtask

  task automatic check_zero();
    chk("zero_cnt_load", cnt_load, 0);
    chk("zero_cnt_mode", cnt_mode, 0);
    chk("zero_cnt_datain", cnt_datain, 0);
    chk("zero_rsp_valid", rsp_valid, 0);
    chk("zero_rsp_id", rsp_id, 0);
    chk("zero_rsp_data", rsp_data, 0);
    chk("zero_rsp_err", rsp_err, 0);
    chk("zero_req0_ready", req0_ready, 0);
    chk("zero_req1_ready", req1_ready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    pc[0] = '{4'd0, 1'b0, 4'd0};
    pc[1] = '{4'd0, 1'b0, 4'd0};
    apply();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_zero();
    @(posedge clk);
    #1 rst = 1'b1;

    offer(0, 10, 1, 3);
    serve(g);
    drain();
    offer(1, 1, 0, 4);
    serve(g);
    drain();
    offer(0, 7, 1, 0);
    serve(g);
    drain();

    // Illegal start with response backpressure and a second request waiting.
    rsp_ready = 1'b0;
    offer(0, 13, 1, 5);
    serve(g);
    offer(1, 5, 1, 2);
    repeat (5) @(posedge clk);
    #1 rsp_ready = 1'b1;
    serve(g);
    drain();

    corrupt = 1'b1;
    offer(0, 4, 0, 6);
    serve(g);
    drain();
    corrupt = 1'b0;

    // Reset in the middle of a long RUN: the command vanishes without a response.
    offer(1, 3, 1, 12);
    serve(g);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    exp_load_cyc = -1;
    mode_m = 0;
    pref = 0;
    @(negedge clk);
    check_zero();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_reset_rsp_valid", rsp_valid, 0);
    end
    @(posedge clk);
    #1;

    offer(0, $urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 15));
    offer(1, $urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 15));
    for (int i = 0; i < 4; i++) begin
      serve(g);
      chk("fair_order", g, i % 2);
      offer(g, $urandom_range(0, 11), $urandom_range(0, 1), $urandom_range(0, 15));
    end
    while (pv[0] || pv[1]) serve(g);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 2) != 0)
          offer(p, $urandom_range(0, 13), $urandom_range(0, 1), $urandom_range(0, 15));
      end
      if (!pv[0] && !pv[1])
        offer($urandom_range(0, 1), $urandom_range(0, 13), $urandom_range(0, 1),
              $urandom_range(0, 15));
      serve(g);
    end
    while (pv[0] || pv[1]) serve(g);
    rand_ready = 1'b0;
    @(posedge clk);
    #2 rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
